// File: rtl/elastic_pipeline.sv
// rtl/elastic_pipeline.sv - elastic valid/ready register pipeline with flush, stall and occupancy count
// Optional per-stage parity tracking is enabled by defining ELASTIC_PIPELINE_PARITY_EN.
module elastic_pipeline #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_data,
  input  logic            out_ready,
  output logic [CNTW-1:0] occupancy,
  output logic            par_err
);

  logic [DEPTH-1:0]            valid_q, valid_d, rdy, up_valid;
  logic [DEPTH-1:0][XLEN-1:0]  data_q, data_d, up_data;
  logic [CNTW-1:0]             occ_q, occ_d;
  logic                        advance;

  assign advance = !stall && !flush;

  // A stage can move when the consumer takes data or any stage at or after it is empty.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = out_ready || ((~valid_q >> i) != '0);
    end
  end

  always_comb begin
    up_valid   = (valid_q << 1) | DEPTH'(in_valid);
    up_data[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_data[i] = data_q[i-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = '0;
    end else if (!stall) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          valid_d[i] = up_valid[i];
          if (up_valid[i]) data_d[i] = up_data[i];
        end
      end
    end
    occ_d = CNTW'($countones(valid_d));
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      valid_q <= '0;
      data_q  <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
    end
  end

  assign in_ready  = resetn && rdy[0] && advance;
  assign out_valid = valid_q[DEPTH-1] && advance;
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;

`ifdef ELASTIC_PIPELINE_PARITY_EN
  logic [DEPTH-1:0] par_q, par_d, up_par;

  // Parity is captured once at the input and then travels alongside its data word.
  always_comb begin
    up_par = (par_q << 1) | DEPTH'(^in_data);
    par_d  = par_q;
    if (advance) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i] && up_valid[i]) par_d[i] = up_par[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) par_q <= '0;
    else         par_q <= par_d;
  end

  assign par_err = out_valid && out_ready && ((^out_data) != par_q[DEPTH-1]);
`else
  assign par_err = 1'b0;
`endif

endmodule
